fir_mac_sequencer: RTL and testbench

//  Time-multiplexed single-MAC FIR engine controller: computes y[n] = sum h[k]*x[n-k], k=0..TAPS-1.

---
 rtl/fir_mac_sequencer.sv | 137 +++++++++++++
 tb/tb_fir_mac_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Single-MAC FIR sequencer: one sample per handshake, TAPS multiply-accumulate cycles,
// then a held, saturated result on a valid/ready output port.
module fir_mac_sequencer #(
  parameter int TAPS = 5,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int OW   = 16,
  localparam int AW  = $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [OW-1:0] m_data,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic signed [CW-1:0] cfg_data,
  output logic                 cfg_err,
  output logic                 busy
);

  localparam int ACCW = DW + CW + $clog2(TAPS);
  localparam int PW   = DW + CW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [AW-1:0]          k_q, k_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [DW-1:0]   dly_q [TAPS];
  logic signed [DW-1:0]   dly_d [TAPS];
  logic signed [CW-1:0]   coef_q [TAPS];
  logic signed [CW-1:0]   coef_d [TAPS];
  logic                   cfg_err_q, cfg_err_d;

  logic [AW-1:0]          rd_idx;
  logic signed [PW-1:0]   prod;
  logic                   accept;
  logic                   cfg_ok;
  logic signed [OW-1:0]   sat_acc;

  assign s_ready = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign m_valid = (state_q == OUT);
  assign cfg_err = cfg_err_q;
  assign accept  = s_valid && s_ready;
  assign cfg_ok  = cfg_we && (state_q == IDLE) && (32'(cfg_addr) < TAPS);

  // Slot of x[n-k] in the ring; modulo-2^AW wrap is harmless since the result is < TAPS.
  assign rd_idx = (wr_ptr_q >= k_q) ? (wr_ptr_q - k_q) : (wr_ptr_q + AW'(TAPS) - k_q);
  assign prod   = coef_q[k_q] * dly_q[rd_idx];

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    wr_ptr_d  = wr_ptr_q;
    acc_d     = acc_q;
    dly_d     = dly_q;
    coef_d    = coef_q;
    cfg_err_d = cfg_we && !cfg_ok;

    if (cfg_ok) begin
      coef_d[cfg_addr] = cfg_data;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          dly_d[wr_ptr_q] = s_data;
          acc_d           = '0;
          k_d             = '0;
          state_d         = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACCW'(prod);
        if (k_q == AW'(TAPS - 1)) begin
          wr_ptr_d = (wr_ptr_q == AW'(TAPS - 1)) ? '0 : wr_ptr_q + AW'(1);
          state_d  = OUT;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      OUT: begin
        if (m_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  generate
    if (ACCW > OW) begin : g_sat
      always_comb begin
        if ((acc_q[ACCW-1:OW-1] == '0) || (acc_q[ACCW-1:OW-1] == '1)) begin
          sat_acc = acc_q[OW-1:0];
        end else if (acc_q[ACCW-1]) begin
          sat_acc = {1'b1, {(OW-1){1'b0}}};
        end else begin
          sat_acc = {1'b0, {(OW-1){1'b1}}};
        end
      end
    end else begin : g_ext
      assign sat_acc = OW'(acc_q);
    end
  endgenerate

  assign m_data = (state_q == OUT) ? sat_acc : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      wr_ptr_q  <= '0;
      acc_q     <= '0;
      dly_q     <= '{default: '0};
      coef_q    <= '{default: '0};
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      wr_ptr_q  <= wr_ptr_d;
      acc_q     <= acc_d;
      dly_q     <= dly_d;
      coef_q    <= coef_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: vector table plus scoreboard of a direct-form FIR model.
module tb_fir_mac_sequencer;
  localparam int TAPS = 5;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int OW   = 16;
  localparam int AW   = $clog2(TAPS);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [DW-1:0] s_data = '0;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic signed [OW-1:0] m_data;
  logic                 cfg_we = 1'b0;
  logic [AW-1:0]        cfg_addr = '0;
  logic signed [CW-1:0] cfg_data = '0;
  logic                 cfg_err;
  logic                 busy;

  fir_mac_sequencer #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int exp;
  } vec_t;

  vec_t tv[12];
  int   n_pass  = 0;
  int   n_total = 0;
  int   exp_q[$];
  int   h_m[TAPS];
  int   x_m[TAPS];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void model_accept(input int x);
    int sum = 0;
    for (int i = TAPS - 1; i > 0; i--) x_m[i] = x_m[i-1];
    x_m[0] = x;
    for (int i = 0; i < TAPS; i++) sum += h_m[i] * x_m[i];
    exp_q.push_back(sat(sum));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      h_m[i] = 0;
      x_m[i] = 0;
    end
    exp_q.delete();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = addr[AW-1:0];
    cfg_data = data[CW-1:0];
    tick();
    cfg_we = 1'b0;
    if (addr < TAPS) h_m[addr] = data;
    check("cfg_err_after_write", int'(cfg_err), (addr >= TAPS) ? 1 : 0);
  endtask

  task automatic accept(input int x);
    int n = 0;
    while (!s_ready && n < 40) begin
      tick();
      n++;
    end
    if (!s_ready) begin
      check("s_ready_timeout", 0, 1);
      return;
    end
    s_valid = 1'b1;
    s_data  = x[DW-1:0];
    tick();
    s_valid = 1'b0;
    model_accept(x);
  endtask

  // Waits for a result, optionally stalls the sink, then consumes it against the scoreboard.
  task automatic collect(input string name, input int hold, input int tbl_exp,
                         input bit use_tbl, output int waited);
    int   held;
    int   exp;
    waited = 0;
    while (!m_valid && waited < 40) begin
      tick();
      waited++;
    end
    if (!m_valid) begin
      check({name, "_timeout"}, 0, 1);
      return;
    end
    held = int'(m_data);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({name, "_hold_valid"}, int'(m_valid), 1);
      check({name, "_hold_data"}, int'(m_data), held);
      check({name, "_hold_sready"}, int'(s_ready), 0);
    end
    if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, int'(m_data), 0);
      exp = 0;
    end else begin
      exp = exp_q.pop_front();
      check({name, "_sb"}, int'(m_data), exp);
    end
    if (use_tbl) check({name, "_tbl"}, int'(m_data), tbl_exp);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check({name, "_mvalid_drop"}, int'(m_valid), 0);
  endtask

  initial begin
    int w;
    int seen;
    tv = '{'{1, 1}, '{0, 2}, '{0, 3}, '{0, 2}, '{0, 1}, '{0, 0},
           '{10, 10}, '{10, 30}, '{10, 60}, '{10, 80}, '{10, 90}, '{10, 90}};
    model_reset();

    tick();
    tick();
    reset = 1'b0;
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_cfg_err", int'(cfg_err), 0);

    cfg_write(0, 1);
    cfg_write(1, 2);
    cfg_write(2, 3);
    cfg_write(3, 2);
    cfg_write(4, 1);

    // Impulse then step.
    for (int i = 0; i < 12; i++) begin
      accept(tv[i].x);
      if (i == 6) begin
        check("step_busy", int'(busy), 1);
        check("step_s_ready", int'(s_ready), 0);
      end
      collect($sformatf("vec%0d", i), 0, tv[i].exp, 1'b1, w);
      if (i == 6) check("step_latency", w, TAPS);
    end

    // Coefficient writes during MAC and out of range are rejected.
    accept(3);
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 8'sd7;
    tick();
    cfg_we = 1'b0;
    check("cfg_err_mac", int'(cfg_err), 1);
    tick();
    check("cfg_err_pulse_end", int'(cfg_err), 0);
    collect("after_mac_cfg", 0, 0, 1'b0, w);
    cfg_write(5, 55);
    tick();
    check("cfg_err_range_end", int'(cfg_err), 0);
    accept(0);
    collect("h_unchanged", 0, 0, 1'b0, w);

    // Coefficient write on the same edge as a sample accept.
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'sd4;
    s_valid = 1'b1; s_data = 8'sd2;
    tick();
    cfg_we = 1'b0; s_valid = 1'b0;
    h_m[0] = 4;
    model_accept(2);
    check("same_edge_cfg_err", int'(cfg_err), 0);
    collect("same_edge", 0, 0, 1'b0, w);

    // Saturation with all -128.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < TAPS; i++) cfg_write(i, -128);
    accept(-128);
    collect("sat0", 0, 16384, 1'b1, w);
    accept(-128);
    collect("sat1", 0, 32767, 1'b1, w);
    accept(-128);
    collect("sat_hold", 10, 32767, 1'b1, w);
    accept(-128);
    collect("sat3", 0, 32767, 1'b1, w);

    // Reset while k=2 in MAC abandons the sample.
    accept(5);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("midrst_busy", int'(busy), 0);
    check("midrst_m_valid", int'(m_valid), 0);
    check("midrst_s_ready", int'(s_ready), 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_valid) seen++;
      tick();
    end
    check("midrst_no_stale", seen, 0);
    cfg_write(0, 1);
    accept(9);
    collect("post_rst", 0, 9, 1'b1, w);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
